riscv_dmem_arbiter: RTL and testbench
=====================================

// Module: riscv_dmem_arbiter
// PURPOSE
//  Shares the single data-memory bus between NREQ requesters (port 0 = core LSU feeding MEM/WB,
//  port 1 = page-table walker/debug). Round-robin arbitration with per-port lock for atomic
//  sequences, and in-order tracking of up to DEPTH outstanding accesses. Each response
//  (ack/err/q/misaligned/page_fault) returns only to the port that issued it. Sits between
//  the requesters and the dmem interface.
// PARAMETERS
//  XLEN   32  data/address width
//  NREQ   2   number of requesters (>=2)
//  DEPTH  2   max outstanding accepted-but-unanswered accesses (power of 2, >=1)
// PORTS
//  clk_i          in   1          clock; all state updates on rising edge
//  rst_ni         in   1          synchronous active-low reset
//  req_i          in   NREQ       per-port access request
//  lock_i         in   NREQ       keep grant on this port after its accepted access
//  adr_i          in   NREQ*XLEN  per-port address
//  we_i           in   NREQ       per-port write enable
//  be_i           in   NREQ*XLEN/8 per-port byte enables
//  d_i            in   NREQ*XLEN  per-port write data
//  gnt_o          out  NREQ       one-hot: access of port i accepted this cycle
//  ack_o          out  NREQ       response (ok) for port i
//  err_o          out  NREQ       response (bus error) for port i
//  misaligned_o   out  NREQ       response (misaligned) for port i
//  page_fault_o   out  NREQ       response (page fault) for port i
//  q_o            out  XLEN       read data (shared; valid with ack_o[i])
//  mem_req_o      out  1          request to memory
//  mem_adr_o/we_o/be_o/d_o out XLEN/1/XLEN/8/XLEN  muxed from selected port
//  mem_stall_i    in   1          memory cannot accept this cycle
//  mem_ack_i/err_i/misaligned_i/page_fault_i in 1  memory response (in order)
//  mem_q_i        in   XLEN       memory read data
//  spurious_o     out  1          pulse: memory response with no outstanding access
// BEHAVIOUR
//  - Reset (rst_ni=0 at clk edge): count=0, rr_ptr=0, lock_owner invalid; all outputs 0.
//  - Selection (comb): if lock_owner valid -> sel=lock_owner (only when req_i[sel]); else
//    first requesting port at or after rr_ptr, wrapping modulo NREQ.
//  - mem_req_o = req_i[sel] & (count<DEPTH); mem_* payload = sel port's, zero-cycle path.
//  - Accept = mem_req_o & ~mem_stall_i; gnt_o[sel]=accept (same cycle, one-hot, else 0).
//  - On accept: push sel into owner FIFO; rr_ptr <= (sel+1)%NREQ;
//    lock_owner <= lock_i[sel] ? sel : invalid.
//  - Locked port deasserting lock_i releases lock next edge even without new accept.
//  - Response = mem_ack_i|err_i|misaligned_i|page_fault_i. If count>0: pop FIFO head h;
//    ack_o[h]/err_o[h]/misaligned_o[h]/page_fault_o[h] mirror mem inputs combinationally
//    same cycle; q_o=mem_q_i. If count==0: drop, spurious_o=1 that cycle, count stays 0.
//  - Simultaneous accept+response: pop then push, count unchanged; response with count==0
//    and accept same cycle -> spurious (new access not matched to it).
//  - FIFO full (count==DEPTH): mem_req_o=0, no gnt; a response the same cycle does NOT
//    enable accept that cycle (no comb path response->grant).
//  - Non-requesting ports never receive gnt; requests may be withdrawn before gnt.
//  - Reset mid-operation clears FIFO; later responses for pre-reset accesses are spurious.
// STRUCTURE
//  - riscv_dmem_pkg: owner id typedef ($clog2(NREQ) bits), dmem_req_t/dmem_rsp_t structs.
//  - Sub-module riscv_dmem_arb_fifo: DEPTH-entry owner-id FIFO (push/pop/count, sync rst).
//  - Top: rr pointer, lock register, select/grant comb, request mux, response demux.
// TESTING
//  1 Port0 reads 0x100, mem_ack_i next cycle q=0xDEADBEEF -> gnt_o=01, then ack_o=01,
//    q_o=0xDEADBEEF, count back 0, no spurious.
//  2 Both ports request continuously, ack every cycle -> gnt_o sequence 01,10,01,10.
//  3 DEPTH=2, no acks, 3 cycles of req0 -> gnt 01,01,00; ack+accept same cycle -> count 2.
//  4 req1 with lock_i[1]=1 for 3 accepts, req0 held -> gnt_o=10 x3, then 01 after release.
//  5 Accepts P0 then P1; responses err then ack -> err_o=01 cycle1, ack_o=10 cycle2.
//  6 Two outstanding, rst_ni=0 one cycle, then mem_ack_i -> no ack_o, spurious_o=1.

Source files
------------

// File: rtl/riscv_dmem_pkg.sv
// Shared types for the data-memory arbiter: bus widths, owner id, request/response bundles.
// Latency and backpressure are properties of the modules that import this package.
package riscv_dmem_pkg;

  localparam int XLEN        = 32;
  localparam int NREQ        = 2;
  localparam int DEF_DEPTH   = 2;
  localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [IDW-1:0] owner_t;

  typedef struct packed {
    logic [XLEN-1:0]   adr;
    logic              we;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   d;
  } dmem_req_t;

  typedef struct packed {
    logic ack;
    logic err;
    logic misaligned;
    logic page_fault;
  } dmem_rsp_t;

  function automatic owner_t next_port(owner_t p);
    return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/riscv_dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = the requesters and memory that surround it.
interface riscv_dmem_arbiter_if;
  import riscv_dmem_pkg::*;

  logic [NREQ-1:0]        req_i;
  logic [NREQ-1:0]        lock_i;
  logic [NREQ*XLEN-1:0]   adr_i;
  logic [NREQ-1:0]        we_i;
  logic [NREQ*XLEN/8-1:0] be_i;
  logic [NREQ*XLEN-1:0]   d_i;
  logic [NREQ-1:0]        gnt_o;
  logic [NREQ-1:0]        ack_o;
  logic [NREQ-1:0]        err_o;
  logic [NREQ-1:0]        misaligned_o;
  logic [NREQ-1:0]        page_fault_o;
  logic [XLEN-1:0]        q_o;
  logic                   mem_req_o;
  logic [XLEN-1:0]        mem_adr_o;
  logic                   mem_we_o;
  logic [XLEN/8-1:0]      mem_be_o;
  logic [XLEN-1:0]        mem_d_o;
  logic                   mem_stall_i;
  logic                   mem_ack_i;
  logic                   mem_err_i;
  logic                   mem_misaligned_i;
  logic                   mem_page_fault_i;
  logic [XLEN-1:0]        mem_q_i;
  logic                   spurious_o;

  modport slave (
    input  req_i, lock_i, adr_i, we_i, be_i, d_i,
    input  mem_stall_i, mem_ack_i, mem_err_i, mem_misaligned_i, mem_page_fault_i, mem_q_i,
    output gnt_o, ack_o, err_o, misaligned_o, page_fault_o, q_o,
    output mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o, spurious_o
  );

  modport master (
    output req_i, lock_i, adr_i, we_i, be_i, d_i,
    output mem_stall_i, mem_ack_i, mem_err_i, mem_misaligned_i, mem_page_fault_i, mem_q_i,
    input  gnt_o, ack_o, err_o, misaligned_o, page_fault_o, q_o,
    input  mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o, spurious_o
  );

endinterface

// File: rtl/riscv_dmem_arb_fifo.sv
// Owner-id FIFO recording which port issued each outstanding access; head is read combinationally.
// Push/pop take effect at the clock edge; the caller must never push when full or pop when empty.
module riscv_dmem_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Round-robin/lockable arbiter sharing one dmem bus; grant and response routing are zero-cycle.
// Stops requesting memory while DEPTH accesses are outstanding; mem_stall_i holds off the grant.
module riscv_dmem_arbiter
  import riscv_dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  riscv_dmem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  owner_t        rr_ptr, lock_id, sel, cand, head;
  logic          lock_vld;
  logic [CW-1:0] count;
  logic          not_full, accept, rsp_any, pop;
  dmem_req_t     req_mux;
  dmem_rsp_t     rsp_in;

  // Descending scan so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    sel  = rr_ptr;
    cand = '0;
    if (lock_vld) begin
      sel = lock_id;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        cand = owner_t'((int'(rr_ptr) + k) % NREQ);
        if (bus.req_i[cand]) sel = cand;
      end
    end
  end

  // Gated by reset so nothing is granted into a FIFO that is being cleared.
  assign not_full      = (count < CW'(DEPTH));
  assign bus.mem_req_o = rst_ni & bus.req_i[sel] & not_full;
  assign accept        = bus.mem_req_o & ~bus.mem_stall_i;
  assign bus.gnt_o     = accept ? (NREQ'(1) << sel) : '0;

  assign req_mux.adr = bus.adr_i[int'(sel)*XLEN +: XLEN];
  assign req_mux.we  = bus.we_i[sel];
  assign req_mux.be  = bus.be_i[int'(sel)*(XLEN/8) +: XLEN/8];
  assign req_mux.d   = bus.d_i[int'(sel)*XLEN +: XLEN];

  assign bus.mem_adr_o = req_mux.adr;
  assign bus.mem_we_o  = req_mux.we;
  assign bus.mem_be_o  = req_mux.be;
  assign bus.mem_d_o   = req_mux.d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
    end else if (accept) begin
      rr_ptr   <= next_port(sel);
      lock_vld <= bus.lock_i[sel];
      lock_id  <= sel;
    end else if (lock_vld && !bus.lock_i[lock_id]) begin
      lock_vld <= 1'b0;
    end
  end

  riscv_dmem_arb_fifo #(.DEPTH(DEPTH), .W(IDW), .CW(CW)) u_owner_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (accept),
    .pop    (pop),
    .wdata  (sel),
    .rdata  (head),
    .count  (count)
  );

  assign rsp_in = {bus.mem_ack_i, bus.mem_err_i, bus.mem_misaligned_i, bus.mem_page_fault_i};
  assign rsp_any = |rsp_in;
  // A response arriving with nothing outstanding is never matched to a same-cycle grant.
  assign pop            = rst_ni & rsp_any & (count != '0);
  assign bus.spurious_o = rst_ni & rsp_any & (count == '0);

  always_comb begin
    bus.ack_o        = '0;
    bus.err_o        = '0;
    bus.misaligned_o = '0;
    bus.page_fault_o = '0;
    bus.q_o          = '0;
    if (pop) begin
      bus.ack_o[head]        = rsp_in.ack;
      bus.err_o[head]        = rsp_in.err;
      bus.misaligned_o[head] = rsp_in.misaligned;
      bus.page_fault_o[head] = rsp_in.page_fault;
      bus.q_o                = bus.mem_q_i;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed bench for riscv_dmem_arbiter: expected grants are per-step constants, response routing
// comes from a queue of owners pushed at each expected grant and popped at each driven response.
module tb_riscv_dmem_arbiter;
  import riscv_dmem_pkg::*;

  localparam logic [31:0] ADR0 = 32'h0000_0100;
  localparam logic [31:0] ADR1 = 32'h0000_0200;
  localparam logic [31:0] D0   = 32'h1111_1111;
  localparam logic [31:0] D1   = 32'h2222_2222;

  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_ACK  = 4'b1000;
  localparam logic [3:0] R_ERR  = 4'b0100;
  localparam logic [3:0] R_MIS  = 4'b0010;
  localparam logic [3:0] R_PF   = 4'b0001;

  logic clk = 1'b0;
  logic rst_n;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   owner_q[$];

  always #5 clk = ~clk;

  riscv_dmem_arbiter_if bus ();

  riscv_dmem_arbiter #(.DEPTH(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs 1ns later.
  task automatic cyc(input string tag, input logic rst, input logic [1:0] req,
                     input logic [1:0] lock, input logic stall, input logic [3:0] rsp,
                     input logic [31:0] q, input logic exp_mreq, input logic [1:0] exp_gnt);
    logic [1:0] e_ack, e_err, e_mis, e_pf;
    logic       e_spur, chk_q;
    int         h;
    @(negedge clk);
    rst_n            = rst;
    bus.req_i        = req;
    bus.lock_i       = lock;
    bus.mem_stall_i  = stall;
    {bus.mem_ack_i, bus.mem_err_i, bus.mem_misaligned_i, bus.mem_page_fault_i} = rsp;
    bus.mem_q_i      = q;
    #1;
    chk({tag, ".count"}, 32'(dut.count), 32'(owner_q.size()));
    e_ack = '0; e_err = '0; e_mis = '0; e_pf = '0; e_spur = 1'b0; chk_q = 1'b0;
    if (rst && rsp != 4'b0000) begin
      if (owner_q.size() > 0) begin
        h     = owner_q.pop_front();
        e_ack = {1'b0, rsp[3]} << h;
        e_err = {1'b0, rsp[2]} << h;
        e_mis = {1'b0, rsp[1]} << h;
        e_pf  = {1'b0, rsp[0]} << h;
        chk_q = 1'b1;
      end else begin
        e_spur = 1'b1;
      end
    end
    chk({tag, ".gnt"},      32'(bus.gnt_o),        32'(exp_gnt));
    chk({tag, ".mem_req"},  32'(bus.mem_req_o),    32'(exp_mreq));
    chk({tag, ".ack"},      32'(bus.ack_o),        32'(e_ack));
    chk({tag, ".err"},      32'(bus.err_o),        32'(e_err));
    chk({tag, ".mis"},      32'(bus.misaligned_o), 32'(e_mis));
    chk({tag, ".pf"},       32'(bus.page_fault_o), 32'(e_pf));
    chk({tag, ".spurious"}, 32'(bus.spurious_o),   32'(e_spur));
    if (chk_q) chk({tag, ".q"}, bus.q_o, q);
    if (exp_gnt == 2'b01) begin
      chk({tag, ".adr"}, bus.mem_adr_o, ADR0);
      chk({tag, ".d"},   bus.mem_d_o,   D0);
      chk({tag, ".we"},  32'(bus.mem_we_o), 32'd0);
      chk({tag, ".be"},  32'(bus.mem_be_o), 32'hF);
      owner_q.push_back(0);
    end else if (exp_gnt == 2'b10) begin
      chk({tag, ".adr"}, bus.mem_adr_o, ADR1);
      chk({tag, ".d"},   bus.mem_d_o,   D1);
      chk({tag, ".we"},  32'(bus.mem_we_o), 32'd1);
      chk({tag, ".be"},  32'(bus.mem_be_o), 32'h3);
      owner_q.push_back(1);
    end
    if (!rst) owner_q.delete();
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.req_i            = '0;
    bus.lock_i           = '0;
    bus.adr_i            = {ADR1, ADR0};
    bus.we_i             = 2'b10;
    bus.be_i             = {4'h3, 4'hF};
    bus.d_i              = {D1, D0};
    bus.mem_stall_i      = 1'b0;
    bus.mem_ack_i        = 1'b0;
    bus.mem_err_i        = 1'b0;
    bus.mem_misaligned_i = 1'b0;
    bus.mem_page_fault_i = 1'b0;
    bus.mem_q_i          = '0;

    //   tag        rst  req    lock   stl  rsp     q             mreq  gnt
    cyc("rst0",     0,   2'b00, 2'b00, 0,   R_NONE, 32'h0,        0,    2'b00);
    cyc("rst1",     0,   2'b00, 2'b00, 0,   R_NONE, 32'h0,        0,    2'b00);

    // single read by port 0
    cyc("t1a",      1,   2'b01, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b01);
    cyc("t1b",      1,   2'b00, 2'b00, 0,   R_ACK,  32'hDEADBEEF, 0,    2'b00);
    cyc("t1c",      1,   2'b00, 2'b00, 0,   R_NONE, 32'h0,        0,    2'b00);

    // both ports streaming, rr_ptr starts at 1 after t1
    cyc("t2a",      1,   2'b11, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b10);
    cyc("t2b",      1,   2'b11, 2'b00, 0,   R_ACK,  32'hA0A0A0A0, 1,    2'b01);
    cyc("t2c",      1,   2'b11, 2'b00, 0,   R_ACK,  32'hA1A1A1A1, 1,    2'b10);
    cyc("t2d",      1,   2'b11, 2'b00, 0,   R_ACK,  32'hA2A2A2A2, 1,    2'b01);
    cyc("t2e",      1,   2'b00, 2'b00, 0,   R_ACK,  32'hA3A3A3A3, 0,    2'b00);

    // fill to DEPTH, response while full must not enable a grant
    cyc("t3a",      1,   2'b01, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b01);
    cyc("t3b",      1,   2'b01, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b01);
    cyc("t3c",      1,   2'b01, 2'b00, 0,   R_NONE, 32'h0,        0,    2'b00);
    cyc("t3d",      1,   2'b01, 2'b00, 0,   R_ACK,  32'hB0B0B0B0, 0,    2'b00);
    cyc("t3e",      1,   2'b01, 2'b00, 0,   R_ACK,  32'hB1B1B1B1, 1,    2'b01);
    cyc("t3f",      1,   2'b01, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b01);
    cyc("t3g",      1,   2'b00, 2'b00, 0,   R_ACK,  32'hB2B2B2B2, 0,    2'b00);
    cyc("t3h",      1,   2'b00, 2'b00, 0,   R_ACK,  32'hB3B3B3B3, 0,    2'b00);

    // port 1 locks for three accepts, then releases without a further accept
    cyc("t4a",      1,   2'b11, 2'b10, 0,   R_NONE, 32'h0,        1,    2'b10);
    cyc("t4b",      1,   2'b11, 2'b10, 0,   R_ACK,  32'hC0C0C0C0, 1,    2'b10);
    cyc("t4c",      1,   2'b11, 2'b10, 0,   R_ACK,  32'hC1C1C1C1, 1,    2'b10);
    cyc("t4d",      1,   2'b01, 2'b00, 0,   R_ACK,  32'hC2C2C2C2, 0,    2'b00);
    cyc("t4e",      1,   2'b01, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b01);
    cyc("t4f",      1,   2'b00, 2'b00, 0,   R_ACK,  32'hC3C3C3C3, 0,    2'b00);

    // in-order error/ack routing, spurious with same-cycle accept, stall
    cyc("t5a",      1,   2'b01, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b01);
    cyc("t5b",      1,   2'b10, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b10);
    cyc("t5c",      1,   2'b00, 2'b00, 0,   R_ERR,  32'h0,        0,    2'b00);
    cyc("t5d",      1,   2'b00, 2'b00, 0,   R_ACK,  32'hD0D0D0D0, 0,    2'b00);
    cyc("t5e",      1,   2'b01, 2'b00, 0,   R_MIS,  32'h0,        1,    2'b01);
    cyc("t5f",      1,   2'b00, 2'b00, 0,   R_PF,   32'h0,        0,    2'b00);
    cyc("t5g",      1,   2'b10, 2'b00, 1,   R_NONE, 32'h0,        1,    2'b00);
    cyc("t5h",      1,   2'b10, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b10);
    cyc("t5i",      1,   2'b00, 2'b00, 0,   R_ACK,  32'h12345678, 0,    2'b00);

    // reset with two outstanding, later response is spurious
    cyc("t6a",      1,   2'b01, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b01);
    cyc("t6b",      1,   2'b10, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b10);
    cyc("t6c",      0,   2'b00, 2'b00, 0,   R_NONE, 32'h0,        0,    2'b00);
    cyc("t6d",      1,   2'b00, 2'b00, 0,   R_ACK,  32'hE0E0E0E0, 0,    2'b00);
    cyc("t6e",      1,   2'b11, 2'b00, 0,   R_NONE, 32'h0,        1,    2'b01);
    cyc("t6f",      1,   2'b00, 2'b00, 0,   R_ACK,  32'hE1E1E1E1, 0,    2'b00);
    cyc("t6g",      1,   2'b00, 2'b00, 0,   R_NONE, 32'h0,        0,    2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
